// File: rtl/gray_binary_converter_pipelined_if.sv
`default_nettype none
// ============================================================================
//  Module   : gray_binary_converter_pipelined_if
//  Brief    : Streaming handshake bundle for the pipelined Gray/Binary converter.
//             Step_Error_Out exists only when GRAY_STEP_CHECK_EN is defined.
//  Revision : 1.0
// ============================================================================
interface gray_binary_converter_pipelined_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  Enable_In;
   logic                  Mode_In;
   logic                  Valid_In;
   logic                  Ready_Out;
   logic [DATA_WIDTH-1:0] Data_In;
   logic                  Valid_Out;
   logic                  Ready_In;
   logic [DATA_WIDTH-1:0] Data_Out;
   logic                  Mode_Out;
`ifdef GRAY_STEP_CHECK_EN
   logic                  Step_Error_Out;

   modport master (
      output Enable_In, Mode_In, Valid_In, Data_In, Ready_In,
      input  Ready_Out, Valid_Out, Data_Out, Mode_Out, Step_Error_Out
   );
   modport slave (
      input  Enable_In, Mode_In, Valid_In, Data_In, Ready_In,
      output Ready_Out, Valid_Out, Data_Out, Mode_Out, Step_Error_Out
   );
`else
   modport master (
      output Enable_In, Mode_In, Valid_In, Data_In, Ready_In,
      input  Ready_Out, Valid_Out, Data_Out, Mode_Out
   );
   modport slave (
      input  Enable_In, Mode_In, Valid_In, Data_In, Ready_In,
      output Ready_Out, Valid_Out, Data_Out, Mode_Out
   );
`endif
endinterface
`default_nettype wire

// File: rtl/gray_binary_converter_pipelined.sv
`default_nettype none
// ============================================================================
//  Module   : gray_binary_converter_pipelined
//  Brief    : Pipelined bidirectional Gray/Binary converter, valid/ready stream.
//             Optional macro GRAY_STEP_CHECK_EN adds the Gray step checker.
//  Revision : 1.0
// ============================================================================
module gray_binary_converter_pipelined #(
   parameter int DATA_WIDTH  = 8,
   parameter int PIPE_STAGES = 2
) (
   input  wire                              Clock_In,
   input  wire                              Reset_n_In,
   gray_binary_converter_pipelined_if.slave bus
);

   localparam int C_CHUNK = (DATA_WIDTH + PIPE_STAGES - 1) / PIPE_STAGES;

   logic [DATA_WIDTH-1:0]  data_q [PIPE_STAGES];
   logic [DATA_WIDTH-1:0]  data_d [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] valid_q;
   logic [PIPE_STAGES-1:0] valid_d;
   logic [PIPE_STAGES-1:0] mode_q;
   logic [PIPE_STAGES-1:0] mode_d;
   logic                   advance;
   logic                   accept;

   // Resolve one MSB-first chunk: bits above the chunk are already binary.
   function automatic logic [DATA_WIDTH-1:0] resolve_chunk(
      input logic [DATA_WIDTH-1:0] word,
      input int                    stage
   );
      logic [DATA_WIDTH-1:0] w;
      int                    hi;
      int                    lo;
      w  = word;
      hi = DATA_WIDTH - 1 - stage * C_CHUNK;
      lo = DATA_WIDTH - (stage + 1) * C_CHUNK;
      for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
         if (i <= hi && i >= lo) begin
            w[i] = w[i] ^ w[i+1];
         end
      end
      return w;
   endfunction

   assign advance       = !valid_q[PIPE_STAGES-1] || bus.Ready_In;
   assign bus.Ready_Out = bus.Enable_In && advance;
   assign accept        = bus.Valid_In && bus.Ready_Out;

   always_comb begin
      data_d[0]  = bus.Mode_In ? (bus.Data_In ^ (bus.Data_In >> 1))
                               : resolve_chunk(bus.Data_In, 0);
      mode_d[0]  = bus.Mode_In;
      valid_d[0] = bus.Valid_In && bus.Enable_In;
      for (int k = 1; k < PIPE_STAGES; k++) begin
         data_d[k]  = mode_q[k-1] ? data_q[k-1] : resolve_chunk(data_q[k-1], k);
         mode_d[k]  = mode_q[k-1];
         valid_d[k] = valid_q[k-1];
      end
   end

`ifdef GRAY_STEP_CHECK_EN
   logic [DATA_WIDTH-1:0]  hist_q;
   logic                   hist_vld_q;
   logic [DATA_WIDTH-1:0]  step_diff;
   logic [PIPE_STAGES-1:0] err_q;
   logic [PIPE_STAGES-1:0] err_d;

   // More than one differing bit <=> diff is neither zero nor a power of two.
   assign step_diff = bus.Data_In ^ hist_q;

   always_comb begin
      err_d[0] = !bus.Mode_In && hist_vld_q &&
                 ((step_diff & (step_diff - {{(DATA_WIDTH-1){1'b0}}, 1'b1})) != '0);
      for (int k = 1; k < PIPE_STAGES; k++) begin
         err_d[k] = err_q[k-1];
      end
   end

   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         hist_q     <= '0;
         hist_vld_q <= 1'b0;
      end else if (accept) begin
         if (bus.Mode_In) begin
            hist_vld_q <= 1'b0;
         end else begin
            hist_q     <= bus.Data_In;
            hist_vld_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         err_q <= '0;
      end else if (advance) begin
         for (int k = 0; k < PIPE_STAGES; k++) begin
            if (valid_d[k]) begin
               err_q[k] <= err_d[k];
            end
         end
      end
   end

   assign bus.Step_Error_Out = err_q[PIPE_STAGES-1];
`endif

   // Payload only loads with a valid word so Data_Out holds across bubbles.
   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         valid_q <= '0;
         mode_q  <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else if (advance) begin
         valid_q <= valid_d;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            if (valid_d[k]) begin
               data_q[k] <= data_d[k];
               mode_q[k] <= mode_d[k];
            end
         end
      end
   end

   assign bus.Valid_Out = valid_q[PIPE_STAGES-1];
   assign bus.Data_Out  = data_q[PIPE_STAGES-1];
   assign bus.Mode_Out  = mode_q[PIPE_STAGES-1];

endmodule
`default_nettype wire
